piso_serializer: RTL and testbench
==================================

Name: piso_serializer

Overview:
- Parallel-in, serial-out transmitter for the PID datapath.
- Captures a WIDTH-bit word, such as the controller output or a register snapshot, using a valid/ready load handshake.
- Shifts the word out one bit at a time on `sout`, with a frame strobe and a completion pulse.
- Drives serial DAC/debug links; it is the outbound counterpart of the parallel registers in the datapath.

Parameters:
- WIDTH, 16: word width in bits; must be >= 2.
- DIV, 1: clock cycles each bit is held on `sout`; must be >= 1.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  parallel word to transmit.
- load_valid  input  1  `in` is valid and requests transmission.
- load_ready  output  1  block can accept a word this cycle.
- sout  output  1  serial data out.
- sframe  output  1  high while a frame's bits are on `sout`.
- done  output  1  one-cycle pulse after the final bit.

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is asynchronous and active-high.
- Reset values:
  - sout=0, sframe=0, done=0, load_ready=1.
  - State IDLE; shift register, bit counter and divider counter all cleared.
- States:
  - IDLE → SHIFT when load_valid && load_ready at a rising edge.
  - SHIFT → IDLE after the final bit has been held DIV cycles.
- Accept:
  - A word is captured only when load_valid && load_ready are both high at a rising edge.
  - `in` is sampled only at that edge; later changes to `in` have no effect.
- Latency:
  - The first bit appears on `sout` in the cycle after the accept edge; sframe=1 and load_ready=0 in that same cycle.
  - Each bit is held exactly DIV cycles.
  - Bit order is MSB-first or LSB-first per MSB_FIRST.
  - sframe stays high for WIDTH*DIV consecutive cycles.
- Completion:
  - In the cycle after the last bit: state IDLE, sframe=0, sout=0, done=1 for exactly one cycle, load_ready=1.
  - A new word may be accepted in the done cycle, so back-to-back frames are separated by exactly one idle cycle.
- load_valid during SHIFT: ignored; no capture, no effect on the frame in flight. The requester holds load_valid until load_ready is seen.
- sout is 0 whenever sframe=0.
- Counters:
  - Bit counter width is $clog2(WIDTH+1); divider counter width is max(1,$clog2(DIV)).
  - Neither counter may wrap during a frame.
  - DIV=1 needs no divider state, i.e. the divider is a constant tick.
- Reset mid-frame: all outputs take their reset values immediately (asynchronously). The frame is aborted with no done pulse. The next accept after deassertion starts a clean frame.
- Reset deassertion: synchronised by the surrounding design; no load occurs on the deassertion edge unless load_valid is high.

Optional Feature:
- Macro: PISO_SERIALIZER_PARITY_EN.
- Defined:
  - An even-parity bit (XOR of all WIDTH captured bits) is appended after the data bits, held DIV cycles.
  - sframe is high for (WIDTH+1)*DIV cycles; done follows the parity bit.
  - Bit counter width is $clog2(WIDTH+2).
- Undefined: no parity bit; frame is WIDTH*DIV cycles; no parity logic is synthesised.

Decomposition:
- Shared package `pid_ser_pkg`:
  - State enum typedef (IDLE, SHIFT).
  - Default WIDTH/DIV localparams.
  - A function returning frame length in bits (WIDTH, or WIDTH+1 with parity).
- Sub-module `ser_bit_tick`: the divider counter. Emits a one-cycle tick every DIV cycles while enabled, and clears on disable and on reset. The main FSM advances a bit on each tick.

Test Plan:
- Reset: assert rst mid-idle and check sout=0, sframe=0, done=0, load_ready=1 immediately, without waiting for a clock edge.
- Basic frame (WIDTH=16, DIV=1, MSB_FIRST=1): load 16'hA5C3 → sout = 1010_0101_1100_0011 on cycles 1..16 after accept; sframe high 16 cycles; done=1 and load_ready=1 on cycle 17.
- Divided, LSB-first (DIV=4, MSB_FIRST=0): load 16'h8001 → bit0=1 for cycles 1–4, zeros through cycle 60, bit15=1 for cycles 61–64; sframe high 64 cycles.
- Handshake: load 16'h1234, then pulse load_valid with 16'hFFFF at bit 5 → ignored and frame unchanged. Hold load_valid with 16'h00FF → accepted in the done cycle; second frame starts one cycle later.
- Abort: assert rst during bit 7 of 16'hFFFF → sout/sframe drop asynchronously and no done. After release, load 16'h0001 → clean 16-bit frame.
- Parity (PISO_SERIALIZER_PARITY_EN): load 16'h0007 → 17th bit=1, sframe 17 cycles. Load 16'h0003 → 17th bit=0.

Source files
------------

// File: rtl/pid_ser_pkg.sv
// Shared types and helpers for the PID-datapath serializer.
// Frame length depends on the PISO_SERIALIZER_PARITY_EN build option.
package pid_ser_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_e;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DIV   = 1;

    // Bits per frame: data bits, plus one even-parity bit when enabled.
    function automatic int frame_bits(input int width);
`ifdef PISO_SERIALIZER_PARITY_EN
        return width + 1;
`else
        return width;
`endif
    endfunction

endpackage

// File: rtl/ser_bit_tick.sv
// Bit-period divider: one-cycle tick every DIV enabled cycles.
// Clears whenever disabled; with DIV=1 it is a plain pass-through of the enable.
module ser_bit_tick #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic tick_o
);

    generate
        if (DIV == 1) begin : g_nodiv
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign tick_o = en_i;
        end else begin : g_div
            localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
            localparam logic [CW-1:0] LAST = CW'(DIV - 1);

            logic [CW-1:0] cnt_q;
            logic [CW-1:0] cnt_d;

            assign tick_o = en_i && (cnt_q == LAST);

            always_comb begin
                cnt_d = '0;
                if (en_i && !tick_o) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/piso_serializer.sv
// Parallel-in serial-out transmitter with valid/ready load and done pulse.
// Optional even-parity trailer bit: define PISO_SERIALIZER_PARITY_EN.
//
// Handshake: a word is taken on a rising edge where load_valid && load_ready;
// load_ready is high exactly when the FSM is IDLE (including the done cycle),
// and the requester must hold load_valid and in stable until that edge.
module piso_serializer
    import pid_ser_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DIV       = DEF_DIV,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             sout,
    output logic             sframe,
    output logic             done,
    output logic             dbg_state_o
);

    localparam int FRAME = frame_bits(WIDTH);
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int BCW = $clog2(WIDTH + 2);
`else
    localparam int BCW = $clog2(WIDTH + 1);
`endif
    localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME - 1);

    ser_state_e       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]   bitcnt_q, bitcnt_d;
    logic             done_q, done_d;
    logic             tick;
    logic             data_bit;

    ser_bit_tick #(
        .DIV(DIV)
    ) u_tick (
        .clk   (clk),
        .rst   (rst),
        .en_i  (state_q == SHIFT),
        .tick_o(tick)
    );

`ifdef PISO_SERIALIZER_PARITY_EN
    logic parity_q, parity_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else begin
            parity_q <= parity_d;
        end
    end

    always_comb begin
        parity_d = parity_q;
        if (state_q == IDLE && load_valid) begin
            parity_d = ^in;
        end
    end

    // The trailer slot follows the last data bit.
    always_comb begin
        if (bitcnt_q == BCW'(WIDTH)) begin
            data_bit = parity_q;
        end else begin
            data_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
        end
    end
`else
    assign data_bit = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
`endif

    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        bitcnt_d = bitcnt_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_valid) begin
                    state_d  = SHIFT;
                    shreg_d  = in;
                    bitcnt_d = '0;
                end
            end
            SHIFT: begin
                if (tick) begin
                    if (bitcnt_q == LAST_BIT) begin
                        state_d  = IDLE;
                        done_d   = 1'b1;
                        bitcnt_d = '0;
                        shreg_d  = '0;
                    end else begin
                        bitcnt_d = bitcnt_q + BCW'(1);
                        shreg_d  = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                                    : {1'b0, shreg_q[WIDTH-1:1]};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shreg_q  <= '0;
            bitcnt_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            shreg_q  <= shreg_d;
            bitcnt_q <= bitcnt_d;
            done_q   <= done_d;
        end
    end

    // Outputs decode straight from registers so reset clears them at once.
    assign sframe      = (state_q == SHIFT);
    assign load_ready  = (state_q == IDLE);
    assign sout        = sframe & data_bit;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: one DIV=1 MSB-first and one DIV=4 LSB-first instance.
// Expected serial stream is built from the word by index arithmetic into a queue.
module tb_piso_serializer;

    localparam int W = 16;
`ifdef PISO_SERIALIZER_PARITY_EN
    localparam int FB = W + 1;
`else
    localparam int FB = W;
`endif

    logic         clk;
    logic         rst;
    logic [W-1:0] din;
    logic         lv_a, lv_b;
    logic         rdy_a, rdy_b, sout_a, sout_b, sf_a, sf_b, done_a, done_b, dbg_a, dbg_b;

    int n_total = 0;
    int n_bad   = 0;
    logic [0:0] exp_q[$];

    piso_serializer #(.WIDTH(W), .DIV(1), .MSB_FIRST(1)) u_a (
        .clk(clk), .rst(rst), .in(din), .load_valid(lv_a), .load_ready(rdy_a),
        .sout(sout_a), .sframe(sf_a), .done(done_a), .dbg_state_o(dbg_a)
    );

    piso_serializer #(.WIDTH(W), .DIV(4), .MSB_FIRST(0)) u_b (
        .clk(clk), .rst(rst), .in(din), .load_valid(lv_b), .load_ready(rdy_b),
        .sout(sout_b), .sframe(sf_b), .done(done_b), .dbg_state_o(dbg_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int div_of(input int which);
        return (which == 0) ? 1 : 4;
    endfunction

    function automatic logic [4:0] obs(input int which);
        if (which == 0) return {sout_a, sf_a, done_a, rdy_a, dbg_a};
        return {sout_b, sf_b, done_b, rdy_b, dbg_b};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic set_lv(input int which, input logic v);
        if (which == 0) lv_a = v;
        else lv_b = v;
    endtask

    // Serial stream the spec describes: bit i of the frame, each held DIV cycles.
    task automatic build_exp(input int which, input logic [W-1:0] w);
        logic b;
        exp_q.delete();
        for (int i = 0; i < FB; i++) begin
            if (i == W) b = ^w;
            else if (which == 0) b = w[W-1-i];
            else b = w[i];
            for (int k = 0; k < div_of(which); k++) exp_q.push_back(b);
        end
    endtask

    task automatic check_idle(input int which, input string tag);
        logic [4:0] o;
        o = obs(which);
        check({tag, "_sout"}, 32'(o[4]), 32'd0);
        check({tag, "_sframe"}, 32'(o[3]), 32'd0);
        check({tag, "_done"}, 32'(o[2]), 32'd0);
        check({tag, "_ready"}, 32'(o[1]), 32'd1);
        check({tag, "_state"}, 32'(o[0]), 32'd0);
    endtask

    task automatic check_shift(input int which, input int c);
        logic [4:0] o;
        logic [0:0] e;
        o = obs(which);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 1'bx;
        check($sformatf("sout_u%0d_c%0d", which, c), 32'(o[4]), 32'(e));
        check("shift_sframe", 32'(o[3]), 32'd1);
        check("shift_done", 32'(o[2]), 32'd0);
        check("shift_ready", 32'(o[1]), 32'd0);
        check("shift_state", 32'(o[0]), 32'd1);
    endtask

    task automatic check_done(input int which);
        logic [4:0] o;
        o = obs(which);
        check("done_sout", 32'(o[4]), 32'd0);
        check("done_sframe", 32'(o[3]), 32'd0);
        check("done_pulse", 32'(o[2]), 32'd1);
        check("done_ready", 32'(o[1]), 32'd1);
        check("done_state", 32'(o[0]), 32'd0);
    endtask

    task automatic idle_cycles(input int which, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_idle(which, "gap");
        end
    endtask

    // One frame. pulse_at: cycle to pulse load_valid with all-ones (ignored);
    // chain_at: cycle from which load_valid is held with chain_word;
    // abort_at: cycle in which rst is asserted mid-frame. 0 disables each.
    task automatic run_frame(input int which, input logic [W-1:0] w, input bit preloaded,
                             input int pulse_at, input int chain_at,
                             input logic [W-1:0] chain_word, input int abort_at);
        int len;
        len = FB * div_of(which);
        build_exp(which, w);
        if (!preloaded) begin
            @(negedge clk);
            check("pre_ready", 32'(obs(which) >> 1) & 32'd1, 32'd1);
            din = w;
            set_lv(which, 1'b1);
        end
        @(negedge clk);
        set_lv(which, 1'b0);
        din = W'($urandom);
        for (int c = 1; c <= len; c++) begin
            if (c > 1) @(negedge clk);
            check_shift(which, c);
            if (c == abort_at) begin
                #2 rst = 1'b1;
                #1 check_idle(which, "abort_async");
                repeat (2) begin
                    @(negedge clk);
                    check_idle(which, "abort_hold");
                end
                rst = 1'b0;
                exp_q.delete();
                return;
            end
            if (pulse_at > 0 && c == pulse_at) begin
                din = '1;
                set_lv(which, 1'b1);
            end else if (pulse_at > 0 && c == pulse_at + 1) begin
                set_lv(which, 1'b0);
                din = W'($urandom);
            end
            if (chain_at > 0 && c == chain_at) begin
                din = chain_word;
                set_lv(which, 1'b1);
            end
        end
        @(negedge clk);
        check_done(which);
    endtask

    initial begin
        logic [W-1:0] w, w2;
        int which, len, p, ch;
        rst  = 1'b1;
        din  = '0;
        lv_a = 1'b0;
        lv_b = 1'b0;
        #1;
        check_idle(0, "reset_a");
        check_idle(1, "reset_b");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        idle_cycles(0, 2);

        run_frame(0, 16'hA5C3, 1'b0, 0, 0, '0, 0);
        idle_cycles(0, 1);
        run_frame(1, 16'h8001, 1'b0, 0, 0, '0, 0);
        idle_cycles(1, 1);

        // Pulse ignored mid-frame, then a held request accepted in the done cycle.
        run_frame(0, 16'h1234, 1'b0, 5, 12, 16'h00FF, 0);
        run_frame(0, 16'h00FF, 1'b1, 0, 0, '0, 0);
        idle_cycles(0, 1);

        @(negedge clk);
        #2 rst = 1'b1;
        #1 check_idle(0, "rst_idle_a");
        check_idle(1, "rst_idle_b");
        @(negedge clk);
        rst = 1'b0;

        run_frame(0, 16'hFFFF, 1'b0, 0, 0, '0, 7);
        run_frame(0, 16'h0001, 1'b0, 0, 0, '0, 0);
        run_frame(1, 16'hFFFF, 1'b0, 0, 0, '0, 30);
        run_frame(1, 16'h0001, 1'b0, 0, 0, '0, 0);

        run_frame(0, 16'h0007, 1'b0, 0, 0, '0, 0);
        run_frame(0, 16'h0003, 1'b0, 0, 0, '0, 0);
        run_frame(1, 16'h0007, 1'b0, 0, 0, '0, 0);

        for (int k = 0; k < 8; k++) begin
            which = k % 2;
            w     = W'($urandom);
            w2    = W'($urandom);
            len   = FB * div_of(which);
            p     = $urandom_range(1, len - 3);
            ch    = $urandom_range(p + 2, len);
            if ($urandom_range(0, 1) == 1) begin
                run_frame(which, w, 1'b0, p, ch, w2, 0);
                run_frame(which, w2, 1'b1, 0, 0, '0, 0);
            end else begin
                run_frame(which, w, 1'b0, p, 0, '0, 0);
            end
            idle_cycles(which, $urandom_range(1, 3));
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
